// File: rtl/opcode_info_pkg.sv
// Shared definitions for the opcode info lookup: info word field layout,
// escape byte constants, escape FSM states and the power-on table contents.
package opcode_info_pkg;

  // Info word field offsets (LSB of each field) for the 23-bit layout.
  localparam int NUMOP_LSB  = 21;
  localparam int OP1_LSB    = 19;
  localparam int OP2_LSB    = 17;
  localparam int SIZE1_LSB  = 15;
  localparam int SIZE2_LSB  = 13;
  localparam int OP1REG_LSB = 9;
  localparam int OP2REG_LSB = 5;
  localparam int GRP_LSB    = 0;
  localparam int INFO_BITS  = 23;

  localparam logic [7:0] ESC_0F = 8'h0F;
  localparam logic [7:0] ESC_38 = 8'h38;
  localparam logic [7:0] ESC_3A = 8'h3A;

  typedef enum logic [1:0] {S_MAP0, S_ESC0F, S_ESC38, S_ESC3A} esc_state_e;

  // Packed view of one info word, MSB first (numop sits at [22:21]).
  typedef struct packed {
    logic [1:0] numop;
    logic [1:0] op1;
    logic [1:0] op2;
    logic [1:0] size1;
    logic [1:0] size2;
    logic [3:0] op1reg;
    logic [3:0] op2reg;
    logic [4:0] grp;
  } info_t;

  // Power-on contents. Unlisted opcodes stay all-zero, which the lookup
  // reports as undefined.
  function automatic logic [INFO_BITS-1:0] default_info(input logic [1:0] map,
                                                        input logic [7:0] idx);
    info_t e;
    e = '0;
    case (map)
      2'd0: begin
        if (idx[7:6] == 2'b00 && idx[2:0] <= 3'd5) begin
          // Classic ALU block: eight groups of six forms each.
          e.numop = 2'd2;
          e.grp   = {2'b00, idx[5:3]};
          case (idx[2:0])
            3'd0:    begin e.op1 = 2'd1; e.op2 = 2'd0; end
            3'd1:    begin e.op1 = 2'd1; e.op2 = 2'd0; e.size1 = 2'd3; e.size2 = 2'd3; end
            3'd2:    begin e.op1 = 2'd0; e.op2 = 2'd1; end
            3'd3:    begin e.op1 = 2'd0; e.op2 = 2'd1; e.size1 = 2'd3; e.size2 = 2'd3; end
            3'd4:    begin e.op1 = 2'd2; e.op2 = 2'd3; end
            default: begin e.op1 = 2'd2; e.op2 = 2'd3; e.size1 = 2'd3; e.size2 = 2'd2; end
          endcase
        end else if (idx[7:3] == 5'b01010) begin
          // push reg
          e.numop  = 2'd1;
          e.op1    = 2'd2;
          e.size1  = 2'd3;
          e.op1reg = {1'b0, idx[2:0]};
          e.grp    = 5'h08;
        end else if (idx == 8'h90) begin
          e.grp = 5'h1F;
        end
      end
      2'd1: begin
        if (idx == 8'h05) begin
          e.grp = 5'h1E;
        end else if (idx[7:4] == 4'h8) begin
          // jcc rel32
          e.numop = 2'd1;
          e.op1   = 2'd3;
          e.size1 = 2'd2;
          e.grp   = {1'b1, idx[3:0]};
        end else if (idx == 8'hAF) begin
          e.numop = 2'd2;
          e.op2   = 2'd1;
          e.size1 = 2'd3;
          e.size2 = 2'd3;
          e.grp   = 5'h0C;
        end
      end
      2'd2: begin
        if (idx < 8'h10) begin
          e.numop = 2'd2;
          e.op2   = 2'd1;
          e.size1 = 2'd1;
          e.size2 = 2'd1;
          e.grp   = {1'b0, idx[3:0]};
        end
      end
      default: begin
        if (idx < 8'h10) begin
          e.numop = 2'd3;
          e.op2   = 2'd1;
          e.size1 = 2'd1;
          e.size2 = 2'd1;
          e.grp   = {1'b1, idx[3:0]};
        end
      end
    endcase
    return e;
  endfunction

endpackage

// File: rtl/opcode_info_lookup_table.sv
// Flop-based opcode info storage: NUM_MAPS x 256 entries, one combinational
// read port and one config write port. Reads see the pre-write value when the
// same entry is written in the same cycle.
// OPINFO_PARITY_EN adds an even-parity bit per entry and flags mismatches.
module opcode_info_lookup_table
  import opcode_info_pkg::*;
#(
  parameter int INFO_W   = 23,
  parameter int NUM_MAPS = 2,
  parameter int MAP_W    = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [MAP_W-1:0]  rd_map,
  input  logic [7:0]        rd_idx,
  output logic [INFO_W-1:0] rd_data,
  output logic              rd_perr,
  input  logic              cfg_we,
  input  logic [MAP_W-1:0]  cfg_map,
  input  logic [7:0]        cfg_idx,
  input  logic [INFO_W-1:0] cfg_data
);

  logic [INFO_W-1:0] tbl_q [NUM_MAPS][256];
  logic              cfg_hit;

`ifdef OPINFO_PARITY_EN
  logic [NUM_MAPS-1:0][255:0] par_q;
`endif

  // Writes to a map index beyond the configured map count are dropped.
  assign cfg_hit = cfg_we && (32'(cfg_map) < NUM_MAPS);
  assign rd_data = tbl_q[rd_map][rd_idx];

`ifdef OPINFO_PARITY_EN
  assign rd_perr = par_q[rd_map][rd_idx] ^ (^rd_data);
`else
  assign rd_perr = 1'b0;
`endif

  // Table storage: reload defaults on reset, otherwise take config writes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int m = 0; m < NUM_MAPS; m++) begin
        for (int i = 0; i < 256; i++) begin
          tbl_q[m][i] <= INFO_W'(default_info(2'(m), 8'(i)));
`ifdef OPINFO_PARITY_EN
          par_q[m][i] <= ^(INFO_W'(default_info(2'(m), 8'(i))));
`endif
        end
      end
    end else if (cfg_hit) begin
      tbl_q[cfg_map][cfg_idx] <= cfg_data;
`ifdef OPINFO_PARITY_EN
      par_q[cfg_map][cfg_idx] <= ^cfg_data;
`endif
    end
  end

endmodule

// File: rtl/opcode_info_lookup.sv
// Opcode info lookup: tracks 0F / 0F 38 / 0F 3A escape prefixes to pick an
// opcode map, then returns the registered info word one cycle after the final
// opcode byte over a valid/ready handshake. Tables are run-time writable.
// Optional build macro: OPINFO_PARITY_EN (per-entry parity, drives out_perr).
module opcode_info_lookup
  import opcode_info_pkg::*;
#(
  parameter int INFO_W   = 23,
  parameter int NUM_MAPS = 2,
  parameter int MAP_W    = (NUM_MAPS > 1) ? $clog2(NUM_MAPS) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_byte,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INFO_W-1:0] out_info,
  output logic [MAP_W-1:0]  out_map,
  output logic [7:0]        out_opcode,
  output logic              out_undef,
  output logic              out_perr,
  input  logic              cfg_we,
  input  logic [MAP_W-1:0]  cfg_map,
  input  logic [7:0]        cfg_idx,
  input  logic [INFO_W-1:0] cfg_data
);

  esc_state_e        state_q, state_d;
  logic              esc_d;
  logic [1:0]        map_d;
  logic [MAP_W-1:0]  rd_map;
  logic [INFO_W-1:0] rd_data;
  logic              rd_perr;
  logic              accept;

  logic              out_valid_q;
  logic [INFO_W-1:0] out_info_q;
  logic [MAP_W-1:0]  out_map_q;
  logic [7:0]        out_opcode_q;
  logic              out_undef_q;
  logic              out_perr_q;

  // Flush keeps the input side open so the fetch queue can drain into it.
  assign in_ready = flush || !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;
  assign rd_map   = MAP_W'(map_d);

  // Escape decode: next state, whether the byte is a prefix, and lookup map.
  always_comb begin
    state_d = S_MAP0;
    esc_d   = 1'b0;
    map_d   = 2'd0;
    case (state_q)
      S_MAP0: begin
        if (NUM_MAPS >= 2 && in_byte == ESC_0F) begin
          esc_d   = 1'b1;
          state_d = S_ESC0F;
        end
      end
      S_ESC0F: begin
        if (NUM_MAPS == 4 && in_byte == ESC_38) begin
          esc_d   = 1'b1;
          state_d = S_ESC38;
        end else if (NUM_MAPS == 4 && in_byte == ESC_3A) begin
          esc_d   = 1'b1;
          state_d = S_ESC3A;
        end else begin
          map_d = 2'd1;
        end
      end
      S_ESC38: map_d = 2'd2;
      default: map_d = 2'd3;
    endcase
  end

  opcode_info_lookup_table #(
    .INFO_W  (INFO_W),
    .NUM_MAPS(NUM_MAPS),
    .MAP_W   (MAP_W)
  ) u_tbl (
    .clk     (clk),
    .reset_n (reset_n),
    .rd_map  (rd_map),
    .rd_idx  (in_byte),
    .rd_data (rd_data),
    .rd_perr (rd_perr),
    .cfg_we  (cfg_we),
    .cfg_map (cfg_map),
    .cfg_idx (cfg_idx),
    .cfg_data(cfg_data)
  );

  // Escape FSM and output register; a consume and a reload can share an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_MAP0;
      out_valid_q  <= 1'b0;
      out_info_q   <= '0;
      out_map_q    <= '0;
      out_opcode_q <= '0;
      out_undef_q  <= 1'b0;
      out_perr_q   <= 1'b0;
    end else if (flush) begin
      state_q     <= S_MAP0;
      out_valid_q <= 1'b0;
    end else begin
      if (out_ready) out_valid_q <= 1'b0;
      if (accept) begin
        state_q <= state_d;
        if (!esc_d) begin
          out_valid_q  <= 1'b1;
          out_info_q   <= rd_data;
          out_map_q    <= rd_map;
          out_opcode_q <= in_byte;
          out_undef_q  <= (rd_data == '0);
          out_perr_q   <= rd_perr;
        end
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_info   = out_info_q;
  assign out_map    = out_map_q;
  assign out_opcode = out_opcode_q;
  assign out_undef  = out_undef_q;
  assign out_perr   = out_perr_q;

endmodule

// File: tb/tb_opcode_info_lookup.sv
// Bench for opcode_info_lookup (4-map build): hand-computed vector table,
// directed back-pressure / cfg / flush / reset sequences, then random traffic
// against a prefix-queue reference model. Parity injection under
// OPINFO_PARITY_EN.
module tb_opcode_info_lookup;
  import opcode_info_pkg::*;

  localparam int IW = 23;
  localparam int NM = 4;
  localparam int MW = 2;

  logic          clk, reset_n;
  logic          in_valid, in_ready, flush;
  logic [7:0]    in_byte;
  logic          out_valid, out_ready, out_undef, out_perr;
  logic [IW-1:0] out_info;
  logic [MW-1:0] out_map;
  logic [7:0]    out_opcode;
  logic          cfg_we;
  logic [MW-1:0] cfg_map;
  logic [7:0]    cfg_idx;
  logic [IW-1:0] cfg_data;

  opcode_info_lookup #(.INFO_W(IW), .NUM_MAPS(NM), .MAP_W(MW)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_byte(in_byte), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_info(out_info),
    .out_map(out_map), .out_opcode(out_opcode), .out_undef(out_undef),
    .out_perr(out_perr),
    .cfg_we(cfg_we), .cfg_map(cfg_map), .cfg_idx(cfg_idx), .cfg_data(cfg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int            map;
    logic [7:0]    opc;
    logic [IW-1:0] info;
    bit            perr;
  } exp_t;

  typedef struct {
    int            n;
    logic [7:0]    b0, b1, b2;
    int            map;
    logic [IW-1:0] info;
  } vec_t;

  exp_t          exp_q[$];
  logic [7:0]    pfx[$];
  logic [IW-1:0] mdl [NM][256];
  bit            bad [NM][256];
  vec_t          vecs[9];
  int            n_chk, n_fail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic void model_reset();
    exp_q.delete();
    pfx.delete();
    for (int m = 0; m < NM; m++)
      for (int i = 0; i < 256; i++) begin
        mdl[m][i] = default_info(2'(m), 8'(i));
        bad[m][i] = 1'b0;
      end
  endfunction

  // Prefix bytes collect in a queue; any non-prefix byte resolves the map
  // from what was collected and clears it.
  function automatic void model_byte(input logic [7:0] b);
    int   m;
    exp_t e;
    if (pfx.size() == 0 && b == 8'h0F && NM >= 2) pfx.push_back(b);
    else if (pfx.size() == 1 && NM == 4 && (b == 8'h38 || b == 8'h3A)) pfx.push_back(b);
    else begin
      if (pfx.size() == 0)      m = 0;
      else if (pfx.size() == 1) m = 1;
      else                      m = (pfx[1] == 8'h38) ? 2 : 3;
      e.map  = m;
      e.opc  = b;
      e.info = mdl[m][b];
      e.perr = bad[m][b];
      exp_q.push_back(e);
      pfx.delete();
    end
  endfunction

  // One clock: check outputs against the model at the falling edge, advance
  // the model with this cycle's handshakes, then step past the rising edge.
  task automatic cycle();
    exp_t e;
    bit   rdy;
    @(negedge clk);
    chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      e = exp_q[0];
      chk("out_map", 32'(out_map), 32'(e.map));
      chk("out_opcode", 32'(out_opcode), 32'(e.opc));
      chk("out_info", 32'(out_info), 32'(e.info));
      chk("out_undef", 32'(out_undef), 32'(e.info == '0));
      chk("out_perr", 32'(out_perr), 32'(e.perr));
    end
    rdy = flush || exp_q.size() == 0 || out_ready;
    chk("in_ready", 32'(in_ready), 32'(rdy));
    if (flush) begin
      exp_q.delete();
      pfx.delete();
    end else begin
      if (out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
      if (in_valid && rdy) model_byte(in_byte);
    end
    if (cfg_we && 32'(cfg_map) < NM) begin
      mdl[cfg_map][cfg_idx] = cfg_data;
      bad[cfg_map][cfg_idx] = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; in_valid = 1'b0; flush = 1'b0; cfg_we = 1'b0; out_ready = 1'b0;
    #2;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_info", 32'(out_info), 0);
    chk("rst_out_map", 32'(out_map), 0);
    chk("rst_out_opcode", 32'(out_opcode), 0);
    chk("rst_out_undef", 32'(out_undef), 0);
    chk("rst_out_perr", 32'(out_perr), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    @(posedge clk);
    #1 reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [7:0] lastb;
    n_chk = 0; n_fail = 0;
    reset_n = 1'b0; in_valid = 1'b0; in_byte = '0; flush = 1'b0; out_ready = 1'b0;
    cfg_we = 1'b0; cfg_map = '0; cfg_idx = '0; cfg_data = '0;

    // Expected info words hand-derived from the field layout.
    vecs[0] = '{1, 8'h01, 8'h00, 8'h00, 0, 23'h49E000};
    vecs[1] = '{1, 8'h06, 8'h00, 8'h00, 0, 23'h000000};
    vecs[2] = '{2, 8'h0F, 8'hAF, 8'h00, 1, 23'h43E00C};
    vecs[3] = '{3, 8'h0F, 8'h38, 8'h00, 2, 23'h42A000};
    vecs[4] = '{2, 8'h0F, 8'h0F, 8'h00, 1, 23'h000000};
    vecs[5] = '{3, 8'h0F, 8'h3A, 8'h05, 3, 23'h62A015};
    vecs[6] = '{1, 8'h90, 8'h00, 8'h00, 0, 23'h00001F};
    vecs[7] = '{2, 8'h0F, 8'h85, 8'h00, 1, 23'h390015};
    vecs[8] = '{1, 8'h53, 8'h00, 8'h00, 0, 23'h318608};

    #1;
    do_reset();

    // Vector table: prefixes stay silent, final byte yields exactly one entry.
    out_ready = 1'b1;
    for (int v = 0; v < 9; v++) begin
      lastb = 8'h00;
      for (int k = 0; k < vecs[v].n; k++) begin
        in_valid = 1'b1;
        in_byte  = (k == 0) ? vecs[v].b0 : (k == 1) ? vecs[v].b1 : vecs[v].b2;
        lastb    = in_byte;
        cycle();
        if (k < vecs[v].n - 1) chk("vec_prefix_quiet", 32'(out_valid), 0);
      end
      in_valid = 1'b0;
      chk("vec_valid", 32'(out_valid), 1);
      chk("vec_map", 32'(out_map), 32'(vecs[v].map));
      chk("vec_opcode", 32'(out_opcode), 32'(lastb));
      chk("vec_info", 32'(out_info), 32'(vecs[v].info));
      chk("vec_undef", 32'(out_undef), 32'(vecs[v].info == '0));
      cycle();
      chk("vec_single", 32'(out_valid), 0);
    end

    // Back-pressure: hold for 5 cycles, then a bubble-free release.
    out_ready = 1'b0; in_valid = 1'b1; in_byte = 8'h01;
    cycle();
    in_byte = 8'h90;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_hold_valid", 32'(out_valid), 1);
      chk("bp_hold_info", 32'(out_info), 32'h49E000);
      chk("bp_hold_opcode", 32'(out_opcode), 32'h01);
    end
    out_ready = 1'b1;
    cycle();
    chk("bp_next_90", 32'(out_info), 32'h00001F);
    in_byte = 8'h53;
    cycle();
    chk("bp_next_53", 32'(out_info), 32'h318608);
    in_valid = 1'b0;
    cycle();
    chk("bp_drained", 32'(out_valid), 0);

    // Config write racing a lookup of the same entry.
    in_valid = 1'b1; in_byte = 8'h06;
    cfg_we = 1'b1; cfg_map = 2'd0; cfg_idx = 8'h06; cfg_data = 23'h1ABCDE;
    cycle();
    cfg_we = 1'b0;
    chk("cfg_old_info", 32'(out_info), 0);
    chk("cfg_old_undef", 32'(out_undef), 1);
    cycle();
    chk("cfg_new_info", 32'(out_info), 32'h1ABCDE);
    chk("cfg_new_undef", 32'(out_undef), 0);
    in_valid = 1'b0;
    cycle();

    // Flush drops a held output and a pending escape.
    out_ready = 1'b0; in_valid = 1'b1; in_byte = 8'h90;
    cycle();
    flush = 1'b1; in_byte = 8'h01;
    #1;
    chk("flush_in_ready", 32'(in_ready), 1);
    cycle();
    flush = 1'b0;
    chk("flush_clears_valid", 32'(out_valid), 0);
    out_ready = 1'b1; in_byte = 8'h0F;
    cycle();
    flush = 1'b1; in_valid = 1'b0;
    cycle();
    flush = 1'b0; in_valid = 1'b1; in_byte = 8'h01;
    cycle();
    in_valid = 1'b0;
    chk("flush_map", 32'(out_map), 0);
    chk("flush_info", 32'(out_info), 32'h49E000);
    cycle();

    // Reset mid-escape: prefix lost, written entry back to default.
    in_valid = 1'b1; in_byte = 8'h0F;
    cycle();
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1; in_byte = 8'h01;
    cycle();
    chk("rstmid_map", 32'(out_map), 0);
    chk("rstmid_info", 32'(out_info), 32'h49E000);
    in_byte = 8'h06;
    cycle();
    chk("rstmid_reload_undef", 32'(out_undef), 1);
    in_valid = 1'b0;
    cycle();

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 5))
        0:       in_byte = 8'h0F;
        1:       in_byte = ($urandom_range(0, 1) != 0) ? 8'h38 : 8'h3A;
        2:       in_byte = 8'($urandom_range(0, 15));
        3:       in_byte = ($urandom_range(0, 1) != 0) ? 8'h06 : 8'h85;
        default: in_byte = 8'($urandom);
      endcase
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 39) == 0);
      cfg_we    = ($urandom_range(0, 9) == 0);
      cfg_map   = MW'($urandom_range(0, NM - 1));
      cfg_idx   = 8'($urandom_range(0, 15));
      cfg_data  = ($urandom_range(0, 3) == 0) ? '0 : IW'($urandom);
      cycle();
    end
    in_valid = 1'b0; flush = 1'b0; cfg_we = 1'b0; out_ready = 1'b1;
    cycle();
    cycle();

`ifdef OPINFO_PARITY_EN
    do_reset();
    out_ready = 1'b1;
    // Default entry 0x01 has six ones, so its correct parity bit is 0.
    force dut.u_tbl.par_q[0][1] = 1'b1;
    bad[0][1] = 1'b1;
    in_valid = 1'b1; in_byte = 8'h01;
    cycle();
    in_valid = 1'b0;
    chk("perr_set", 32'(out_perr), 1);
    cycle();
    release dut.u_tbl.par_q[0][1];
    cfg_we = 1'b1; cfg_map = 2'd0; cfg_idx = 8'h01; cfg_data = 23'h49E000;
    cycle();
    cfg_we = 1'b0; in_valid = 1'b1; in_byte = 8'h01;
    cycle();
    in_valid = 1'b0;
    chk("perr_clear", 32'(out_perr), 0);
    cycle();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
